// File: rtl/id_ctrl_pkg.sv
// id_ctrl_pkg: shared decode definitions for the D-stage controller.
// Holds the MIPS opcode/funct constants, the extender select codes
// (EXT_ZERO/EXT_SIGN/EXT_HIGH/EXT_NONE), the E-stage control word and its
// BUBBLE value. No ports.
package id_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Immediate extender selects
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HIGH = 2'd2;
  localparam logic [1:0] EXT_NONE = 2'd3;

  // Control word carried from D into E. md_div picks the busy length.
  typedef struct packed {
    logic [1:0] ext_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] wb_dst;
    logic       md_start;
    logic       md_div;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{ext_op: EXT_NONE, reg_write: 1'b0, mem_read: 1'b0,
                               mem_write: 1'b0, wb_dst: 5'd0, md_start: 1'b0,
                               md_div: 1'b0};

endpackage

// File: rtl/id_ctrl_if.sv
// id_ctrl_if: D-stage controller bus.
// master (pipeline/bench side) drives instr_d/valid_d; slave (id_ctrl)
// returns ext_op_d, stall, the E-stage control fields and md_busy.
interface id_ctrl_if;
  import id_ctrl_pkg::*;

  logic [31:0] instr_d;
  logic        valid_d;
  logic [1:0]  ext_op_d;
  logic        stall;
  logic [1:0]  ext_op_e;
  logic        reg_write_e;
  logic        mem_read_e;
  logic        mem_write_e;
  logic [4:0]  wb_dst_e;
  logic        md_start_e;
  logic        md_busy;

  modport master (
    output instr_d, valid_d,
    input  ext_op_d, stall, ext_op_e, reg_write_e, mem_read_e, mem_write_e,
           wb_dst_e, md_start_e, md_busy
  );

  modport slave (
    input  instr_d, valid_d,
    output ext_op_d, stall, ext_op_e, reg_write_e, mem_read_e, mem_write_e,
           wb_dst_e, md_start_e, md_busy
  );
endinterface

// File: rtl/id_decode.sv
// id_decode: pure combinational MIPS instruction decoder.
// Ports: instr/valid in; ctrl (control word), rs/rt fields, uses_rs/uses_rt
// (source register usage) and md_class (touches the MD unit) out.
// An invalid slot decodes as a bubble.
module id_decode
  import id_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_t       ctrl,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        md_class
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rd_s;
  logic [4:0] unused_shamt_s;

  assign op_s           = instr[31:26];
  assign rs             = instr[25:21];
  assign rt             = instr[20:16];
  assign rd_s           = instr[15:11];
  assign unused_shamt_s = instr[10:6];
  assign funct_s        = instr[5:0];

  // Decode opcode/funct into control word and register usage
  always_comb begin
    ctrl     = BUBBLE;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    md_class = 1'b0;
    if (valid) begin
      case (op_s)
        OP_RTYPE: begin
          uses_rs = 1'b1;
          case (funct_s)
            FN_SLL, FN_SRL, FN_SRA: begin
              uses_rs     = 1'b0;
              uses_rt     = 1'b1;
              ctrl.wb_dst = rd_s;
            end
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: begin
              uses_rt     = 1'b1;
              ctrl.wb_dst = rd_s;
            end
            FN_MFHI, FN_MFLO: begin
              uses_rs     = 1'b0;
              md_class    = 1'b1;
              ctrl.wb_dst = rd_s;
            end
            FN_MTHI, FN_MTLO: md_class = 1'b1;
            FN_MULT, FN_MULTU: begin
              uses_rt       = 1'b1;
              md_class      = 1'b1;
              ctrl.md_start = 1'b1;
            end
            FN_DIV, FN_DIVU: begin
              uses_rt       = 1'b1;
              md_class      = 1'b1;
              ctrl.md_start = 1'b1;
              ctrl.md_div   = 1'b1;
            end
            default: ctrl.wb_dst = 5'd0; // jr and unknown functs write nothing
          endcase
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
          ctrl.ext_op = EXT_SIGN;
          ctrl.wb_dst = rt;
          uses_rs     = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          ctrl.ext_op = EXT_ZERO;
          ctrl.wb_dst = rt;
          uses_rs     = 1'b1;
        end
        OP_LUI: begin
          ctrl.ext_op = EXT_HIGH;
          ctrl.wb_dst = rt;
        end
        OP_LW: begin
          ctrl.ext_op   = EXT_SIGN;
          ctrl.wb_dst   = rt;
          ctrl.mem_read = 1'b1;
          uses_rs       = 1'b1;
        end
        OP_SW: begin
          ctrl.ext_op    = EXT_SIGN;
          ctrl.mem_write = 1'b1;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ctrl.ext_op = EXT_SIGN;
          uses_rs     = 1'b1;
          uses_rt     = 1'b1;
        end
        OP_JAL:  ctrl.wb_dst = 5'd31;
        OP_J:    ctrl.wb_dst = 5'd0;
        default: ctrl = BUBBLE;
      endcase
    end else begin
      ctrl = BUBBLE;
    end
    // A write to $0 is no write at all
    ctrl.reg_write = (ctrl.wb_dst != 5'd0);
  end

endmodule

// File: rtl/id_ctrl.sv
// id_ctrl: decode-stage controller of the 5-stage MIPS pipeline.
// Ports: clk, reset (synchronous, active low), bus (id_ctrl_if.slave):
//   instr_d/valid_d in; ext_op_d, stall (combinational), E-stage control
//   fields and md_busy out.
// Detects load-use and MD-busy hazards, holds the D->E control register and
// counts down the busy window of the multi-cycle mult/div unit.
module id_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  id_ctrl_if.slave  bus
);

  localparam int CNT_W = ($clog2(DIV_CYCLES) > 4) ? $clog2(DIV_CYCLES) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t            dec_ctrl_s;
  ctrl_t            ctrl_e_r;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  logic             uses_rs_s;
  logic             uses_rt_s;
  logic             md_class_s;
  logic             load_use_s;
  logic             md_busy_s;
  logic             stall_s;
  logic [CNT_W-1:0] cnt_r;

  id_decode u_decode (
    .instr    (bus.instr_d),
    .valid    (bus.valid_d),
    .ctrl     (dec_ctrl_s),
    .rs       (rs_s),
    .rt       (rt_s),
    .uses_rs  (uses_rs_s),
    .uses_rt  (uses_rt_s),
    .md_class (md_class_s)
  );

  // Hazard detection: load-use against the E-stage load, MD access while busy
  always_comb begin
    load_use_s = 1'b0;
    if (ctrl_e_r.mem_read && (ctrl_e_r.wb_dst != 5'd0)) begin
      load_use_s = (uses_rs_s && (rs_s == ctrl_e_r.wb_dst)) ||
                   (uses_rt_s && (rt_s == ctrl_e_r.wb_dst));
    end else begin
      load_use_s = 1'b0;
    end
    // The E cycle of a mult/div counts as busy before the counter is loaded
    md_busy_s = ctrl_e_r.md_start || (cnt_r != CNT_ZERO);
    stall_s   = load_use_s || (md_class_s && md_busy_s);
  end

  // D->E control register; a stall inserts a bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e_r <= BUBBLE;
    end else if (stall_s) begin
      ctrl_e_r <= BUBBLE;
    end else begin
      ctrl_e_r <= dec_ctrl_s;
    end
  end

  // MD busy counter: loads N-1 at the end of the E cycle, then counts to 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
    end else if (ctrl_e_r.md_start) begin
      cnt_r <= ctrl_e_r.md_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.ext_op_d    = dec_ctrl_s.ext_op;
  assign bus.stall       = stall_s;
  assign bus.ext_op_e    = ctrl_e_r.ext_op;
  assign bus.reg_write_e = ctrl_e_r.reg_write;
  assign bus.mem_read_e  = ctrl_e_r.mem_read;
  assign bus.mem_write_e = ctrl_e_r.mem_write;
  assign bus.wb_dst_e    = ctrl_e_r.wb_dst;
  assign bus.md_start_e  = ctrl_e_r.md_start;
  assign bus.md_busy     = md_busy_s;

endmodule

// File: tb/tb_id_ctrl.sv
// tb_id_ctrl: self-checking bench for id_ctrl. A behavioural model tracks
// which instruction sits in E and how many MD-busy cycles remain; every
// cycle all outputs are compared. Directed sequences pin the model with
// hand-computed values, then randomized instruction streams follow.
module tb_id_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int NT     = 33;
  localparam logic [31:0] TMPL [0:NT-1] = '{
    32'h00000000, 32'h00000002, 32'h00000003, 32'h00000008, 32'h00000010,
    32'h00000011, 32'h00000012, 32'h00000013, 32'h00000018, 32'h00000019,
    32'h0000001A, 32'h0000001B, 32'h00000021, 32'h00000023, 32'h00000024,
    32'h0000002A, 32'h0000003F, 32'h20000000, 32'h24000000, 32'h28000000,
    32'h2C000000, 32'h30000000, 32'h34000000, 32'h38000000, 32'h3C000000,
    32'h8C000000, 32'h8C000000, 32'hAC000000, 32'h10000000, 32'h14000000,
    32'h08000000, 32'h0C000000, 32'hFC000000
  };

  logic clk = 1'b0;
  logic reset;
  id_ctrl_if bus();

  id_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: instruction occupying E (e_v = 0 means bubble), busy cycles left
  logic [31:0] e_ins;
  logic        e_v;
  int          md_rem;
  logic        last_stall;
  int          vectors;
  int          miscompares;

  function automatic bit alu_r(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B};
  endfunction

  function automatic logic [4:0] m_dst(input logic [31:0] i, input logic v);
    logic [5:0] op = i[31:26];
    logic [5:0] f  = i[5:0];
    if (!v) return 5'd0;
    if (op == 6'h00) return (alu_r(f) || f == 6'h10 || f == 6'h12) ? i[15:11] : 5'd0;
    if (op inside {[6'h08:6'h0F], 6'h23}) return i[20:16];
    if (op == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [1:0] m_ext(input logic [31:0] i, input logic v);
    logic [5:0] op = i[31:26];
    if (!v) return 2'd3;
    if (op inside {6'h0C, 6'h0D, 6'h0E}) return 2'd0;
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05}) return 2'd1;
    if (op == 6'h0F) return 2'd2;
    return 2'd3;
  endfunction

  function automatic bit m_md_start(input logic [31:0] i, input logic v);
    return v && i[31:26] == 6'h00 && (i[5:0] inside {[6'h18:6'h1B]});
  endfunction

  function automatic bit m_md_class(input logic [31:0] i, input logic v);
    return v && i[31:26] == 6'h00 && (i[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
  endfunction

  function automatic bit m_reads(input logic [31:0] i, input logic v, input logic [4:0] r);
    logic [5:0] op = i[31:26];
    logic [5:0] f  = i[5:0];
    bit rs_used, rt_used;
    if (!v) return 1'b0;
    if (op == 6'h00) begin
      rs_used = !(f inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h12});
      rt_used = alu_r(f) || (f inside {[6'h18:6'h1B]});
    end else begin
      rs_used = op inside {6'h04, 6'h05, [6'h08:6'h0E], 6'h23, 6'h2B};
      rt_used = op inside {6'h04, 6'h05, 6'h2B};
    end
    return (rs_used && i[25:21] == r) || (rt_used && i[20:16] == r);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // One cycle: drive D, compare every output against the model, advance model
  task automatic step(input logic [31:0] ins, input logic v, input logic r);
    logic [4:0] e_dst;
    logic       e_load;
    logic       exp_st;
    @(negedge clk);
    bus.instr_d = ins;
    bus.valid_d = v;
    reset       = r;
    #1;
    vectors++;
    e_dst  = m_dst(e_ins, e_v);
    e_load = e_v && (e_ins[31:26] == 6'h23);
    exp_st = (e_load && e_dst != 5'd0 && m_reads(ins, v, e_dst)) ||
             (m_md_class(ins, v) && md_rem > 0);
    chk("ext_op_d",    bus.ext_op_d,    m_ext(ins, v));
    chk("stall",       bus.stall,       exp_st);
    chk("ext_op_e",    bus.ext_op_e,    m_ext(e_ins, e_v));
    chk("wb_dst_e",    bus.wb_dst_e,    e_dst);
    chk("reg_write_e", bus.reg_write_e, e_dst != 5'd0);
    chk("mem_read_e",  bus.mem_read_e,  e_load);
    chk("mem_write_e", bus.mem_write_e, e_v && e_ins[31:26] == 6'h2B);
    chk("md_start_e",  bus.md_start_e,  m_md_start(e_ins, e_v));
    chk("md_busy",     bus.md_busy,     md_rem > 0);
    if (!r) begin
      e_v    = 1'b0;
      md_rem = 0;
    end else begin
      if (md_rem > 0) md_rem--;
      if (exp_st) begin
        e_v = 1'b0;
      end else begin
        e_ins = ins;
        e_v   = v;
        if (m_md_start(ins, v)) md_rem = (ins[5:0] inside {6'h1A, 6'h1B}) ? DIV_N : MULT_N;
      end
    end
    last_stall = exp_st;
  endtask

  initial begin
    logic [31:0] ins;
    logic        v;
    vectors     = 0;
    miscompares = 0;
    bus.instr_d = 32'd0;
    bus.valid_d = 1'b0;
    reset       = 1'b0;
    e_ins       = 32'd0;
    e_v         = 1'b0;
    md_rem      = 0;
    last_stall  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(32'd0, 1'b0, 1'b1);
    chk("rst_ext_op_e", bus.ext_op_e, 32'd3);
    chk("rst_reg_write_e", bus.reg_write_e, 32'd0);
    chk("rst_md_busy", bus.md_busy, 32'd0);

    // Extender selects and destinations
    step(32'h3C011234, 1'b1, 1'b1);
    chk("lui_ext_op_d", bus.ext_op_d, 32'd2);
    chk("lui_stall", bus.stall, 32'd0);
    step(32'h34220005, 1'b1, 1'b1);
    chk("ori_ext_op_d", bus.ext_op_d, 32'd0);
    chk("lui_ext_op_e", bus.ext_op_e, 32'd2);
    chk("lui_wb_dst_e", bus.wb_dst_e, 32'd1);
    chk("lui_reg_write_e", bus.reg_write_e, 32'd1);
    step(32'h2403FFFF, 1'b1, 1'b1);
    chk("addiu_ext_op_d", bus.ext_op_d, 32'd1);
    step(32'h00221821, 1'b1, 1'b1);
    chk("addu_ext_op_d", bus.ext_op_d, 32'd3);
    step(32'd0, 1'b0, 1'b1);
    chk("addu_wb_dst_e", bus.wb_dst_e, 32'd3);

    // Load-use: one stall cycle with a bubble; sw and $0 loads do not stall
    step(32'h8C220000, 1'b1, 1'b1);
    step(32'h00411821, 1'b1, 1'b1);
    chk("lu_stall", bus.stall, 32'd1);
    chk("lu_mem_read_e", bus.mem_read_e, 32'd1);
    step(32'h00411821, 1'b1, 1'b1);
    chk("lu_stall_drop", bus.stall, 32'd0);
    chk("lu_bubble_wb", bus.wb_dst_e, 32'd0);
    step(32'hAC220000, 1'b1, 1'b1);
    step(32'h00411821, 1'b1, 1'b1);
    chk("sw_no_stall", bus.stall, 32'd0);
    step(32'h8C200000, 1'b1, 1'b1);
    step(32'h00011821, 1'b1, 1'b1);
    chk("lw0_no_stall", bus.stall, 32'd0);

    // mult then mflo: five stall cycles
    step(32'h00220018, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(32'h00002012, 1'b1, 1'b1);
      chk("mult_stall", bus.stall, 32'd1);
      chk("mult_busy", bus.md_busy, 32'd1);
    end
    step(32'h00002012, 1'b1, 1'b1);
    chk("mult_stall_end", bus.stall, 32'd0);
    chk("mult_busy_end", bus.md_busy, 32'd0);
    step(32'd0, 1'b0, 1'b1);
    chk("mflo_wb_dst_e", bus.wb_dst_e, 32'd4);

    // div aborted by reset
    step(32'h0022001A, 1'b1, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    chk("div_busy_c1", bus.md_busy, 32'd1);
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b0);
    chk("div_busy_c3", bus.md_busy, 32'd1);
    step(32'h00002012, 1'b1, 1'b1);
    chk("div_abort_busy", bus.md_busy, 32'd0);
    chk("div_abort_ext", bus.ext_op_e, 32'd3);
    chk("div_abort_stall", bus.stall, 32'd0);

    // Invalid slot is a NOP
    step(32'h8C220000, 1'b0, 1'b1);
    chk("inv_stall", bus.stall, 32'd0);
    chk("inv_ext_op_d", bus.ext_op_d, 32'd3);
    step(32'd0, 1'b0, 1'b1);
    chk("inv_reg_write_e", bus.reg_write_e, 32'd0);
    chk("inv_mem_read_e", bus.mem_read_e, 32'd0);

    // Randomized stream; a stalled D instruction is held
    ins = 32'd0;
    v   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        ins          = TMPL[$urandom_range(0, NT - 1)];
        ins[25:21]   = 5'($urandom_range(0, 3));
        ins[20:16]   = 5'($urandom_range(0, 3));
        ins[15:11]   = 5'($urandom_range(0, 3));
        ins[10:6]    = 5'($urandom_range(0, 31));
        v            = ($urandom_range(0, 7) != 0);
      end
      step(ins, v, $urandom_range(0, 49) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
